gray_ptr_ctrl: RTL and testbench
================================

GRAY_PTR_CTRL -- requirements
Module: gray_ptr_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, sets the FIFO address width; DEPTH = 2^ADDR_WIDTH; legal range is ADDR_WIDTH >= 2.
REQ-002 Parameter MODE, default 0, selects the side: 0 = write side (flag means full), 1 = read side (flag means empty).
REQ-003 Parameter ALMOST_TH, default 2, is the almost-flag threshold in entries; legal range is 1..DEPTH-1.
REQ-004 Port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port i_inc, input, 1 bit: pointer advance request (write enable or read enable).
REQ-007 Port i_remote_gray, input, ADDR_WIDTH+1 bits: opposite-side Gray pointer, already synchronised into i_clk by the instantiating logic.
REQ-008 Port o_addr, output, ADDR_WIDTH bits: RAM address, equal to o_bin_ptr[ADDR_WIDTH-1:0].
REQ-009 Port o_bin_ptr, output, ADDR_WIDTH+1 bits: registered binary pointer including the wrap bit.
REQ-010 Port o_gray_ptr, output, ADDR_WIDTH+1 bits: registered Gray encoding of o_bin_ptr.
REQ-011 Port o_flag, output, 1 bit: registered full flag (MODE 0) or empty flag (MODE 1).
REQ-012 Port o_almost, output, 1 bit: registered almost-full flag (MODE 0) or almost-empty flag (MODE 1).
REQ-013 Port o_level, output, ADDR_WIDTH+1 bits: registered occupancy as seen by this side, range 0..DEPTH.

Function
REQ-014 The pointer shall advance exactly when i_inc = 1 and o_flag = 0; otherwise all pointer registers hold their value.
REQ-015 Advance: bin_next = o_bin_ptr + 1, computed modulo 2^(ADDR_WIDTH+1); the value 2^(ADDR_WIDTH+1)-1 wraps to 0.
REQ-016 o_gray_ptr shall load bin_next XOR (bin_next >> 1) on the same edge as o_bin_ptr, so the two outputs are never inconsistent.
REQ-017 o_flag shall be re-evaluated every cycle from the post-edge Gray pointer (g) and the current i_remote_gray (r), whether or not the pointer advances.
- MODE 0 (full): g == {~r[ADDR_WIDTH:ADDR_WIDTH-1], r[ADDR_WIDTH-2:0]}.
- MODE 1 (empty): g == r.
REQ-018 Flag latency: a write that fills the last entry sets o_flag on that same edge; a request made while o_flag = 1 is dropped silently.
REQ-019 Remote pointer decode: remote_bin[ADDR_WIDTH] = r[ADDR_WIDTH]; remote_bin[i] = remote_bin[i+1] XOR r[i].
REQ-020 Level: MODE 0 = post-edge binary pointer minus remote_bin; MODE 1 = remote_bin minus post-edge binary pointer. Both are modulo 2^(ADDR_WIDTH+1) and registered.
REQ-021 o_almost: MODE 0 asserts when level >= DEPTH-ALMOST_TH; MODE 1 asserts when level <= ALMOST_TH. It is registered in the same cycle as o_level.
REQ-022 A change on i_remote_gray alone, with i_inc = 0, shall update o_flag, o_level and o_almost one edge later.

Reset
REQ-023 When i_rst = 1 at a clock edge, i_rst shall take priority over i_inc.
REQ-024 Reset values: o_bin_ptr = 0, o_gray_ptr = 0, o_addr = 0, o_level = 0.
REQ-025 Reset values of the flags: o_flag = MODE; o_almost = MODE.
REQ-026 A reset asserted mid-operation shall discard pointer state in one cycle; the opposite side is reset by the same i_rst.

Configuration
REQ-027 Macro GRAY_PTR_LEVEL_EN: when defined, the remote decode, level subtractor, o_level and o_almost are compiled in as specified above.
REQ-028 When GRAY_PTR_LEVEL_EN is undefined, o_level and o_almost shall be constant 0 and contain no logic; o_flag, the pointers and all other behaviour are unchanged.

Verification (ADDR_WIDTH=4, ALMOST_TH=2, GRAY_PTR_LEVEL_EN defined unless stated)
REQ-029 Reset: MODE 1, drive i_rst = 1 with i_inc = 1 -> pointers = 0, o_flag = 1, o_almost = 1, o_level = 0; no advance occurs.
REQ-030 Fill: MODE 0, r = 0, 16 consecutive incs -> o_bin_ptr = 5'b10000, o_gray_ptr = 5'b11000, o_flag = 1 after the 16th edge, o_almost = 1 from the 14th edge; a 17th inc leaves the pointer unchanged.
REQ-031 Wrap: MODE 0, r tracks this side's pointer (the FIFO stays non-full), 32 incs -> o_bin_ptr steps 31 to 0 and o_gray_ptr steps 5'b10000 to 5'b00000; o_flag stays 0 throughout.
REQ-032 Drain: MODE 1, r = 5'b00011 (binary 2), o_level = 2; two incs -> o_level goes 1 then 0, o_flag = 1 after the second inc; a third inc is ignored.
REQ-033 Remote-only update: MODE 0 full, r changes from 5'b00000 to 5'b00001 with i_inc = 0 -> o_flag = 0 and o_level = 15 after one edge.
REQ-034 Macro off: repeat REQ-030 with GRAY_PTR_LEVEL_EN undefined -> o_level = 0 and o_almost = 0 every cycle; o_flag and the pointers are identical to REQ-030.

Source files
------------

// File: rtl/gray_ptr_ctrl.sv
// rtl/gray_ptr_ctrl.sv - Gray-coded FIFO pointer with full/empty flag for one side of an async FIFO
// Define GRAY_PTR_LEVEL_EN to compile in remote decode, o_level and o_almost.
module gray_ptr_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int MODE       = 0,
  parameter int ALMOST_TH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_inc,
  input  logic [ADDR_WIDTH:0]   i_remote_gray,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [ADDR_WIDTH:0]   o_bin_ptr,
  output logic [ADDR_WIDTH:0]   o_gray_ptr,
  output logic                  o_flag,
  output logic                  o_almost,
  output logic [ADDR_WIDTH:0]   o_level
);

  localparam int   PW        = ADDR_WIDTH + 1;
  localparam int   DEPTH     = 1 << ADDR_WIDTH;
  localparam logic RST_FLAG  = (MODE != 0);

  logic [ADDR_WIDTH:0] bin_q, bin_d, bin_inc;
  logic [ADDR_WIDTH:0] gray_q, gray_d;
  logic                flag_q, flag_d;
  logic                adv;

  assign adv     = i_inc & ~flag_q;
  assign bin_inc = bin_q + PW'(1);
  assign bin_d   = adv ? bin_inc : bin_q;
  assign gray_d  = bin_d ^ (bin_d >> 1);

  // Flags look at the post-edge pointer so a filling write flags full on the same edge.
  generate
    if (MODE == 0) begin : g_full
      assign flag_d = (gray_d == {~i_remote_gray[ADDR_WIDTH:ADDR_WIDTH-1],
                                   i_remote_gray[ADDR_WIDTH-2:0]});
    end else begin : g_empty
      assign flag_d = (gray_d == i_remote_gray);
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      flag_q <= RST_FLAG;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      flag_q <= flag_d;
    end
  end

  assign o_bin_ptr  = bin_q;
  assign o_gray_ptr = gray_q;
  assign o_addr     = bin_q[ADDR_WIDTH-1:0];
  assign o_flag     = flag_q;

`ifdef GRAY_PTR_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] ALMOST_FULL_LVL  = PW'(DEPTH - ALMOST_TH);
  localparam logic [ADDR_WIDTH:0] ALMOST_EMPTY_LVL = PW'(ALMOST_TH);

  logic [ADDR_WIDTH:0] remote_bin;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                almost_q, almost_d;

  // Each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar i = 0; i <= ADDR_WIDTH; i++) begin : g_dec
      assign remote_bin[i] = ^i_remote_gray[ADDR_WIDTH:i];
    end
  endgenerate

  always_comb begin
    level_d  = '0;
    almost_d = 1'b0;
    if (MODE == 0) begin
      level_d  = bin_d - remote_bin;
      almost_d = (level_d >= ALMOST_FULL_LVL);
    end else begin
      level_d  = remote_bin - bin_d;
      almost_d = (level_d <= ALMOST_EMPTY_LVL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      level_q  <= '0;
      almost_q <= RST_FLAG;
    end else begin
      level_q  <= level_d;
      almost_q <= almost_d;
    end
  end

  assign o_level  = level_q;
  assign o_almost = almost_q;
`else
  assign o_level  = '0;
  assign o_almost = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// tb/tb_gray_ptr_ctrl.sv - scoreboard bench for gray_ptr_ctrl, write-side and read-side instances
module tb_gray_ptr_ctrl;

`ifdef GRAY_PTR_LEVEL_EN
  localparam bit LV = 1'b1;
`else
  localparam bit LV = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] bin;
    logic [4:0] gray;
    logic [3:0] addr;
    logic       flag;
    logic       almost;
    logic [4:0] level;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_inc, r_inc;
  logic [4:0] w_remote, r_remote;

  logic [3:0] w_addr, r_addr;
  logic [4:0] w_bin, w_gray, w_level, r_bin, r_gray, r_level;
  logic       w_flag, w_almost, r_flag, r_almost;

  obs_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  gray_ptr_ctrl #(.ADDR_WIDTH(4), .MODE(0), .ALMOST_TH(2)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_inc(w_inc), .i_remote_gray(w_remote),
    .o_addr(w_addr), .o_bin_ptr(w_bin), .o_gray_ptr(w_gray),
    .o_flag(w_flag), .o_almost(w_almost), .o_level(w_level)
  );

  gray_ptr_ctrl #(.ADDR_WIDTH(4), .MODE(1), .ALMOST_TH(2)) dut_r (
    .i_clk(clk), .i_rst(rst), .i_inc(r_inc), .i_remote_gray(r_remote),
    .o_addr(r_addr), .o_bin_ptr(r_bin), .o_gray_ptr(r_gray),
    .o_flag(r_flag), .o_almost(r_almost), .o_level(r_level)
  );

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic obs_t mk(input int b, input logic f, input logic a, input int lvl);
    obs_t o;
    logic [4:0] bb;
    bb       = b[4:0];
    o.bin    = bb;
    o.gray   = to_gray(bb);
    o.addr   = bb[3:0];
    o.flag   = f;
    o.almost = LV ? a : 1'b0;
    o.level  = LV ? lvl[4:0] : 5'd0;
    return o;
  endfunction

  function automatic obs_t obs_w();
    obs_t o;
    o.bin = w_bin; o.gray = w_gray; o.addr = w_addr;
    o.flag = w_flag; o.almost = w_almost; o.level = w_level;
    return o;
  endfunction

  function automatic obs_t obs_r();
    obs_t o;
    o.bin = r_bin; o.gray = r_gray; o.addr = r_addr;
    o.flag = r_flag; o.almost = r_almost; o.level = r_level;
    return o;
  endfunction

  task automatic do_reset();
    rst = 1'b1; w_inc = 1'b0; r_inc = 1'b0; w_remote = '0; r_remote = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, got;
    rst = 1'b1; w_inc = 1'b1; r_inc = 1'b1; w_remote = '0; r_remote = 5'b00011;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(0, 1'b1, 1'b1, 0));
      exp_q.push_back(mk(0, 1'b0, 1'b0, 0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); got = obs_r(); n_total++;
      if (got !== e) $display("FAIL reset_rd[%0d] got=%h exp=%h", k, got, e);
      else n_pass++;
      e = exp_q.pop_front(); got = obs_w(); n_total++;
      if (got !== e) $display("FAIL reset_wr[%0d] got=%h exp=%h", k, got, e);
      else n_pass++;
    end
    rst = 1'b0; w_inc = 1'b0; r_inc = 1'b0;
  endtask

  task automatic test_fill();
    obs_t e, got;
    do_reset();
    w_remote = '0;
    for (int k = 1; k <= 17; k++) begin
      w_inc = 1'b1;
      exp_q.push_back(mk((k > 16) ? 16 : k, k >= 16, k >= 14, (k > 16) ? 16 : k));
      @(posedge clk); #1;
      e = exp_q.pop_front(); got = obs_w(); n_total++;
      if (got !== e) $display("FAIL fill[%0d] got=%h exp=%h", k, got, e);
      else n_pass++;
    end
    n_total++;
    if (w_gray !== 5'b11000) $display("FAIL fill_gray got=%b exp=11000", w_gray);
    else n_pass++;
    w_inc = 1'b0;
  endtask

  task automatic test_remote_only();
    obs_t e, got;
    w_inc = 1'b0; w_remote = 5'b00001;
    exp_q.push_back(mk(16, 1'b0, 1'b1, 15));
    @(posedge clk); #1;
    e = exp_q.pop_front(); got = obs_w(); n_total++;
    if (got !== e) $display("FAIL remote_only got=%h exp=%h", got, e);
    else n_pass++;
    w_inc = 1'b1;
    exp_q.push_back(mk(17, 1'b1, 1'b1, 16));
    @(posedge clk); #1;
    e = exp_q.pop_front(); got = obs_w(); n_total++;
    if (got !== e) $display("FAIL refill got=%h exp=%h", got, e);
    else n_pass++;
    w_inc = 1'b0;
  endtask

  task automatic test_wrap();
    obs_t e, got;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      w_inc    = 1'b1;
      w_remote = to_gray(5'(k - 1));
      exp_q.push_back(mk(k % 32, 1'b0, 1'b0, 1));
      @(posedge clk); #1;
      e = exp_q.pop_front(); got = obs_w(); n_total++;
      if (got !== e) $display("FAIL wrap[%0d] got=%h exp=%h", k, got, e);
      else n_pass++;
      if (k == 31) begin
        n_total++;
        if (w_gray !== 5'b10000) $display("FAIL wrap_gray31 got=%b exp=10000", w_gray);
        else n_pass++;
      end
    end
    w_inc = 1'b0;
  endtask

  task automatic test_drain();
    obs_t e, got;
    do_reset();
    r_remote = 5'b00011;
    exp_q.push_back(mk(0, 1'b0, 1'b1, 2));
    @(posedge clk); #1;
    e = exp_q.pop_front(); got = obs_r(); n_total++;
    if (got !== e) $display("FAIL drain_prime got=%h exp=%h", got, e);
    else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      r_inc = 1'b1;
      exp_q.push_back(mk((k > 2) ? 2 : k, k >= 2, 1'b1, (k >= 2) ? 0 : 1));
      @(posedge clk); #1;
      e = exp_q.pop_front(); got = obs_r(); n_total++;
      if (got !== e) $display("FAIL drain[%0d] got=%h exp=%h", k, got, e);
      else n_pass++;
    end
    r_inc = 1'b0;
  endtask

  task automatic test_back_to_back_reset();
    obs_t e, got;
    do_reset();
    w_remote = '0;
    for (int k = 1; k <= 8; k++) begin
      w_inc = 1'b1;
      rst   = (k == 6);
      if (k < 6)       exp_q.push_back(mk(k, 1'b0, 1'b0, k));
      else if (k == 6) exp_q.push_back(mk(0, 1'b0, 1'b0, 0));
      else             exp_q.push_back(mk(k - 6, 1'b0, 1'b0, k - 6));
      @(posedge clk); #1;
      e = exp_q.pop_front(); got = obs_w(); n_total++;
      if (got !== e) $display("FAIL midreset[%0d] got=%h exp=%h", k, got, e);
      else n_pass++;
    end
    rst = 1'b0; w_inc = 1'b0;
  endtask

  initial begin
    rst = 1'b1; w_inc = 1'b0; r_inc = 1'b0; w_remote = '0; r_remote = '0;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_remote_only();
    test_wrap();
    test_drain();
    test_back_to_back_reset();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
